// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load requesters, the decode scoreboard port and the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADR_W  = 2
);
  localparam int unsigned NREG = 2 ** ADR_W;

  logic              alu_valid;
  logic [ADR_W-1:0]  alu_adr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADR_W-1:0]  mem_adr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              issue_en;
  logic [ADR_W-1:0]  issue_adr;

  logic [NREG-1:0]   busy;
  logic              rf_write_en;
  logic [ADR_W-1:0]  rf_write_adr;
  logic [DATA_W-1:0] rf_write_data;
  logic              grant_src;
  logic              wb_unexpected;

  // Requester / environment side.
  modport master (
    output alu_valid, alu_adr, alu_data,
    output mem_valid, mem_adr, mem_data,
    output issue_en, issue_adr,
    input  alu_ready, mem_ready,
    input  busy, rf_write_en, rf_write_adr, rf_write_data, grant_src, wb_unexpected
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_adr, alu_data,
    input  mem_valid, mem_adr, mem_data,
    input  issue_en, issue_adr,
    output alu_ready, mem_ready,
    output busy, rf_write_en, rf_write_adr, rf_write_data, grant_src, wb_unexpected
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin between ALU and load unit, registered write port,
// per-register pending-write scoreboard and a sticky unexpected-writeback flag.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADR_W  = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned NREG = 2 ** ADR_W;

  logic              alu_rdy, mem_rdy, xfer;
  logic [ADR_W-1:0]  gnt_adr;
  logic [DATA_W-1:0] gnt_data;

  logic              prio_q, prio_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              we_q, we_d;
  logic [ADR_W-1:0]  wadr_q, wadr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              src_q, src_d;
  logic              unexp_q, unexp_d;

  // Grant: lone requester wins; on contention prio_q picks (0 ALU, 1 load). Nothing while in reset.
  always_comb begin
    alu_rdy = 1'b0;
    mem_rdy = 1'b0;
    if (rst_ni) begin
      if (bus.alu_valid && (!bus.mem_valid || !prio_q)) begin
        alu_rdy = 1'b1;
      end else if (bus.mem_valid) begin
        mem_rdy = 1'b1;
      end
    end
  end

  assign xfer     = alu_rdy | mem_rdy;
  assign gnt_adr  = mem_rdy ? bus.mem_adr  : bus.alu_adr;
  assign gnt_data = mem_rdy ? bus.mem_data : bus.alu_data;

  // Next-state for write port, priority pointer and scoreboard.
  always_comb begin
    prio_d  = prio_q;
    busy_d  = busy_q;
    we_d    = xfer;
    wadr_d  = wadr_q;
    wdata_d = wdata_q;
    src_d   = src_q;
    unexp_d = unexp_q;
    if (xfer) begin
      prio_d  = ~mem_rdy;
      wadr_d  = gnt_adr;
      wdata_d = gnt_data;
      src_d   = mem_rdy;
      busy_d[gnt_adr] = 1'b0;
      if (!busy_q[gnt_adr]) begin
        unexp_d = 1'b1;
      end
    end
    // Applied after the clear so a same-register issue keeps the bit set.
    if (bus.issue_en) begin
      busy_d[bus.issue_adr] = 1'b1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q  <= 1'b0;
      busy_q  <= '0;
      we_q    <= 1'b0;
      wadr_q  <= '0;
      wdata_q <= '0;
      src_q   <= 1'b0;
      unexp_q <= 1'b0;
    end else begin
      prio_q  <= prio_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      wadr_q  <= wadr_d;
      wdata_q <= wdata_d;
      src_q   <= src_d;
      unexp_q <= unexp_d;
    end
  end

  assign bus.alu_ready     = alu_rdy;
  assign bus.mem_ready     = mem_rdy;
  assign bus.busy          = busy_q;
  assign bus.rf_write_en   = we_q;
  assign bus.rf_write_adr  = wadr_q;
  assign bus.rf_write_data = wdata_q;
  assign bus.grant_src     = src_q;
  assign bus.wb_unexpected = unexp_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  regfile_wb_arbiter_if #(.DATA_W(16), .ADR_W(2)) bus ();

  regfile_wb_arbiter #(.DATA_W(16), .ADR_W(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_wr(input string tag, input logic [31:0] adr, input logic [31:0] data,
                          input logic [31:0] src);
    check_eq({tag, ".we"}, 32'(bus.rf_write_en), 32'd1);
    check_eq({tag, ".adr"}, 32'(bus.rf_write_adr), adr);
    check_eq({tag, ".data"}, 32'(bus.rf_write_data), data);
    check_eq({tag, ".src"}, 32'(bus.grant_src), src);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_adr   = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b1;
    bus.mem_adr   = '0;
    bus.mem_data  = '0;
    bus.issue_en  = 1'b0;
    bus.issue_adr = '0;

    // Reset state, with both requests asserted to show ready is suppressed.
    #2;
    check_eq("rst.alu_ready", 32'(bus.alu_ready), 32'd0);
    check_eq("rst.mem_ready", 32'(bus.mem_ready), 32'd0);
    check_eq("rst.we", 32'(bus.rf_write_en), 32'd0);
    check_eq("rst.busy", 32'(bus.busy), 32'd0);
    check_eq("rst.unexp", 32'(bus.wb_unexpected), 32'd0);
    @(negedge clk);
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    rst_n = 1'b1;

    // Contention: issue r0, r1; ALU r0 wins first, load r1 second.
    bus.issue_en = 1'b1; bus.issue_adr = 2'd0;
    cyc();
    bus.issue_adr = 2'd1;
    cyc();
    bus.issue_en = 1'b0;
    check_eq("cont.busy", 32'(bus.busy), 32'h3);
    bus.alu_valid = 1'b1; bus.alu_adr = 2'd0; bus.alu_data = 16'hCCCC;
    bus.mem_valid = 1'b1; bus.mem_adr = 2'd1; bus.mem_data = 16'hAAAA;
    #1;
    check_eq("cont1.alu_ready", 32'(bus.alu_ready), 32'd1);
    check_eq("cont1.mem_ready", 32'(bus.mem_ready), 32'd0);
    cyc();
    bus.alu_valid = 1'b0;
    check_wr("cont1", 32'd0, 32'hCCCC, 32'd0);
    #1;
    check_eq("cont2.mem_ready", 32'(bus.mem_ready), 32'd1);
    check_eq("cont2.alu_ready", 32'(bus.alu_ready), 32'd0);
    cyc();
    bus.mem_valid = 1'b0;
    check_wr("cont2", 32'd1, 32'hAAAA, 32'd1);
    check_eq("cont2.busy", 32'(bus.busy), 32'h0);
    cyc();
    check_eq("idle.we", 32'(bus.rf_write_en), 32'd0);
    check_eq("idle.data_hold", 32'(bus.rf_write_data), 32'hAAAA);
    check_eq("idle.src_hold", 32'(bus.grant_src), 32'd1);

    // Fairness: both valid for 6 cycles; re-issue the granted register so nothing is unexpected.
    bus.issue_en = 1'b1; bus.issue_adr = 2'd2;
    cyc();
    bus.issue_adr = 2'd3;
    cyc();
    check_eq("fair.busy0", 32'(bus.busy), 32'hC);
    for (int k = 0; k < 6; k++) begin
      bus.alu_valid = 1'b1; bus.alu_adr = 2'd2; bus.alu_data = 16'(16'h1000 + k / 2);
      bus.mem_valid = 1'b1; bus.mem_adr = 2'd3; bus.mem_data = 16'(16'h2000 + k / 2);
      bus.issue_adr = (k % 2 == 1) ? 2'd3 : 2'd2;
      #1;
      check_eq($sformatf("fair%0d.alu_ready", k), 32'(bus.alu_ready), 32'(k % 2 == 0));
      check_eq($sformatf("fair%0d.mem_ready", k), 32'(bus.mem_ready), 32'(k % 2 == 1));
      cyc();
      check_eq($sformatf("fair%0d.src", k), 32'(bus.grant_src), 32'(k % 2));
      check_eq($sformatf("fair%0d.data", k), 32'(bus.rf_write_data),
               (k % 2 == 1) ? 32'(32'h2000 + k / 2) : 32'(32'h1000 + k / 2));
    end
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.issue_en = 1'b0;
    check_eq("fair.busy1", 32'(bus.busy), 32'hC);
    check_eq("fair.unexp", 32'(bus.wb_unexpected), 32'd0);

    // Same-register collision: issue r3 and load writeback r3 on one edge.
    bus.issue_en = 1'b1; bus.issue_adr = 2'd3;
    bus.mem_valid = 1'b1; bus.mem_adr = 2'd3; bus.mem_data = 16'h5A5A;
    cyc();
    bus.issue_en = 1'b0; bus.mem_valid = 1'b0;
    check_wr("coll", 32'd3, 32'h5A5A, 32'd1);
    check_eq("coll.busy", 32'(bus.busy), 32'hC);
    check_eq("coll.unexp", 32'(bus.wb_unexpected), 32'd0);

    // Different registers: issue r0 while ALU writes back r2.
    bus.issue_en = 1'b1; bus.issue_adr = 2'd0;
    bus.alu_valid = 1'b1; bus.alu_adr = 2'd2; bus.alu_data = 16'h0F0F;
    cyc();
    bus.issue_en = 1'b0; bus.alu_valid = 1'b0;
    check_wr("diff", 32'd2, 32'h0F0F, 32'd0);
    check_eq("diff.busy", 32'(bus.busy), 32'h9);

    // Unexpected writeback to non-busy r1.
    bus.alu_valid = 1'b1; bus.alu_adr = 2'd1; bus.alu_data = 16'h1234;
    cyc();
    bus.alu_valid = 1'b0;
    check_wr("err", 32'd1, 32'h1234, 32'd0);
    check_eq("err.unexp", 32'(bus.wb_unexpected), 32'd1);
    cyc();
    cyc();
    check_eq("err.sticky", 32'(bus.wb_unexpected), 32'd1);
    check_eq("err.busy", 32'(bus.busy), 32'h9);

    // Async reset during contention while prio points at the load unit.
    bus.alu_valid = 1'b1; bus.alu_adr = 2'd0; bus.alu_data = 16'hCCCC;
    bus.mem_valid = 1'b1; bus.mem_adr = 2'd3; bus.mem_data = 16'h3333;
    #1;
    check_eq("prerst.mem_ready", 32'(bus.mem_ready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.alu_ready", 32'(bus.alu_ready), 32'd0);
    check_eq("arst.mem_ready", 32'(bus.mem_ready), 32'd0);
    check_eq("arst.we", 32'(bus.rf_write_en), 32'd0);
    check_eq("arst.adr", 32'(bus.rf_write_adr), 32'd0);
    check_eq("arst.data", 32'(bus.rf_write_data), 32'd0);
    check_eq("arst.src", 32'(bus.grant_src), 32'd0);
    check_eq("arst.busy", 32'(bus.busy), 32'd0);
    check_eq("arst.unexp", 32'(bus.wb_unexpected), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post.alu_ready", 32'(bus.alu_ready), 32'd1);
    check_eq("post.mem_ready", 32'(bus.mem_ready), 32'd0);
    cyc();
    check_wr("post", 32'd0, 32'hCCCC, 32'd0);
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
